// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell encoding, checker states
// and the winning-line table used by the board reader.
package ttt_pkg;

    localparam int CELL_W    = 2;
    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = CELL_W * NUM_CELLS;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P0    = 2'b01,
        CELL_P1    = 2'b10,
        CELL_BAD   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    typedef logic [3:0]       cidx_t;
    typedef cidx_t [2:0]      line_t;

    // Element [0] is the first cell of the line.
    function automatic line_t line_cells(input logic [2:0] idx);
        line_t l;
        unique case (idx)
            3'd0:    l = {4'd2, 4'd1, 4'd0};
            3'd1:    l = {4'd5, 4'd4, 4'd3};
            3'd2:    l = {4'd8, 4'd7, 4'd6};
            3'd3:    l = {4'd6, 4'd3, 4'd0};
            3'd4:    l = {4'd7, 4'd4, 4'd1};
            3'd5:    l = {4'd8, 4'd5, 4'd2};
            3'd6:    l = {4'd8, 4'd4, 4'd0};
            default: l = {4'd6, 4'd4, 4'd2};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ttt_line_sel.sv
// Picks the three cells of one winning line from the
// board snapshot and flags a completed line.
module ttt_line_sel
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] snap_i,
    input  logic [2:0]         line_idx_i,
    output cell_t              cell_a_o,
    output cell_t              cell_b_o,
    output cell_t              cell_c_o,
    output logic               line_win_o,
    output logic               line_owner_o
);

    line_t idx;

    always_comb begin
        idx      = line_cells(line_idx_i);
        cell_a_o = cell_t'(snap_i[{idx[0], 1'b0} +: CELL_W]);
        cell_b_o = cell_t'(snap_i[{idx[1], 1'b0} +: CELL_W]);
        cell_c_o = cell_t'(snap_i[{idx[2], 1'b0} +: CELL_W]);
        line_win_o = (cell_a_o == cell_b_o)
                  && (cell_b_o == cell_c_o)
                  && (cell_a_o != CELL_EMPTY);
        line_owner_o = (cell_a_o == CELL_P1);
    end

endmodule

// File: rtl/board_result_checker.sv
// Snapshots the board on request, scans the eight lines one
// per cycle and reports winner, draw or corrupted board.
module board_result_checker
    import ttt_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [BOARD_W-1:0] board_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               winner_valid_o,
    output logic               winner_id_o,
    output logic [2:0]         win_line_o,
    output logic               draw_o,
    output logic               board_error_o
);

    chk_state_t         state_q;
    logic [2:0]         line_idx_q;
    logic [BOARD_W-1:0] snap_q;
    logic               busy_q;
    logic               done_q;
    logic               wv_q;
    logic               wid_q;
    logic [2:0]         wline_q;
    logic               draw_q;
    logic               err_q;

    cell_t cell_a, cell_b, cell_c;
    logic  line_win, line_owner;
    logic  any_bad, any_empty;
    logic  unused_cells;

    ttt_line_sel u_sel (
        .snap_i       (snap_q),
        .line_idx_i   (line_idx_q),
        .cell_a_o     (cell_a),
        .cell_b_o     (cell_b),
        .cell_c_o     (cell_c),
        .line_win_o   (line_win),
        .line_owner_o (line_owner)
    );

    assign unused_cells = ^{cell_a, cell_b, cell_c};

    always_comb begin
        any_bad   = 1'b0;
        any_empty = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (snap_q[CELL_W*k +: CELL_W] == CELL_BAD)
                any_bad = 1'b1;
            if (snap_q[CELL_W*k +: CELL_W] == CELL_EMPTY)
                any_empty = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            line_idx_q <= '0;
            snap_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wv_q       <= 1'b0;
            wid_q      <= 1'b0;
            wline_q    <= '0;
            draw_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        snap_q     <= board_i;
                        line_idx_q <= '0;
                        wv_q       <= 1'b0;
                        wid_q      <= 1'b0;
                        wline_q    <= '0;
                        draw_q     <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    // Corruption is only checked before line 0 is scanned.
                    if (line_idx_q == 3'd0 && any_bad) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (line_win && !wv_q) begin
                            wv_q    <= 1'b1;
                            wid_q   <= line_owner;
                            wline_q <= line_idx_q;
                        end
                        if (line_win && EARLY_EXIT) begin
                            state_q <= DONE;
                        end else begin
                            line_idx_q <= line_idx_q + 3'd1;
                            if (line_idx_q == 3'(NUM_LINES - 1))
                                state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    draw_q  <= !wv_q && !err_q && !any_empty;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign winner_valid_o = wv_q;
    assign winner_id_o    = wid_q;
    assign win_line_o     = wline_q;
    assign draw_o         = draw_q;
    assign board_error_o  = err_q;

endmodule

// File: tb/tb_board_result_checker.sv
// Scoreboard bench for board_result_checker with early exit
// enabled (u_ee) and disabled (u_full) instances side by side.
module tb_board_result_checker;

    typedef struct {
        logic       wv;
        logic       wid;
        logic [2:0] wl;
        logic       draw;
        logic       err;
        int         lat;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [17:0] board;
    logic        start1, start0;

    logic       busy1, done1, wv1, wid1, draw1, err1;
    logic [2:0] wl1;
    logic       busy0, done0, wv0, wid0, draw0, err0;
    logic [2:0] wl0;

    int   cyc;
    int   acc1, acc0;
    int   n_cmp, n_bad;
    exp_t q1[$];
    exp_t q0[$];

    board_result_checker #(.EARLY_EXIT(1'b1)) u_ee (
        .clock_i        (clock),
        .reset_i        (reset),
        .board_i        (board),
        .start_i        (start1),
        .busy_o         (busy1),
        .done_o         (done1),
        .winner_valid_o (wv1),
        .winner_id_o    (wid1),
        .win_line_o     (wl1),
        .draw_o         (draw1),
        .board_error_o  (err1)
    );

    board_result_checker #(.EARLY_EXIT(1'b0)) u_full (
        .clock_i        (clock),
        .reset_i        (reset),
        .board_i        (board),
        .start_i        (start0),
        .busy_o         (busy0),
        .done_o         (done0),
        .winner_valid_o (wv0),
        .winner_id_o    (wid0),
        .win_line_o     (wl0),
        .draw_o         (draw0),
        .board_error_o  (err0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(
        input logic [1:0] c0, c1, c2,
        input logic [1:0] c3, c4, c5,
        input logic [1:0] c6, c7, c8
    );
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic exp_t model(input logic [17:0] b, input bit ee);
        int lt [8][3] = '{
            '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
            '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
            '{0, 4, 8}, '{2, 4, 6}
        };
        exp_t       e;
        bit         bad, emp;
        int         wl;
        logic [1:0] a, m, c;
        bad = 0;
        emp = 0;
        wl  = -1;
        e.wid = 0;
        for (int k = 0; k < 9; k++) begin
            if (b[2*k +: 2] == 2'b11) bad = 1;
            if (b[2*k +: 2] == 2'b00) emp = 1;
        end
        for (int l = 0; l < 8; l++) begin
            a = b[2*lt[l][0] +: 2];
            m = b[2*lt[l][1] +: 2];
            c = b[2*lt[l][2] +: 2];
            if (wl < 0 && a != 2'b00 && a == m && m == c) begin
                wl    = l;
                e.wid = (a == 2'b10);
            end
        end
        if (bad) begin
            e.wv = 0; e.wid = 0; e.wl = 0;
            e.draw = 0; e.err = 1; e.lat = 2;
        end else begin
            e.err  = 0;
            e.wv   = (wl >= 0);
            e.wl   = e.wv ? 3'(wl) : 3'd0;
            e.draw = !e.wv && !emp;
            e.lat  = (ee && e.wv) ? wl + 2 : 9;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("ee_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("ee_latency", cyc - acc1, e.lat);
                chk("ee_winner_valid", wv1, e.wv);
                chk("ee_winner_id", wid1, e.wid);
                chk("ee_win_line", wl1, e.wl);
                chk("ee_draw", draw1, e.draw);
                chk("ee_board_error", err1, e.err);
            end
        end
    end

    always @(negedge clock) begin
        if (done0) begin
            if (q0.size() == 0) begin
                chk("full_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("full_latency", cyc - acc0, e.lat);
                chk("full_winner_valid", wv0, e.wv);
                chk("full_winner_id", wid0, e.wid);
                chk("full_win_line", wl0, e.wl);
                chk("full_draw", draw0, e.draw);
                chk("full_board_error", err0, e.err);
            end
        end
    end

    // sel=1 drives the early-exit instance, sel=0 the full-scan one.
    task automatic run(
        input logic [17:0] b,
        input bit          sel,
        input bit          rewrite,
        input bit          dbl
    );
        exp_t e;
        bit   got;
        e = model(b, sel);
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
        @(negedge clock);
        board = b;
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        start0 = 1'b0;
        if (sel) acc1 = cyc;
        else     acc0 = cyc;
        chk("busy_after_accept", sel ? busy1 : busy0, 1);
        if (rewrite) board = ~b;
        got = (sel ? done1 : done0);
        if (dbl && !got) begin
            if (sel) start1 = 1'b1;
            else     start0 = 1'b1;
            @(negedge clock);
            start1 = 1'b0;
            start0 = 1'b0;
            got = (sel ? done1 : done0);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = (sel ? done1 : done0);
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            if (sel) q1.delete();
            else     q0.delete();
        end
        repeat (3) @(negedge clock);
        chk("hold_winner_valid", sel ? wv1 : wv0, e.wv);
        chk("hold_draw", sel ? draw1 : draw0, e.draw);
        chk("idle_busy", sel ? busy1 : busy0, 0);
    endtask

    function automatic int outs1();
        return int'({busy1, done1, wv1, wid1, wl1, draw1, err1});
    endfunction

    function automatic int outs0();
        return int'({busy0, done0, wv0, wid0, wl0, draw0, err0});
    endfunction

    logic [17:0] empty_b, row0_b, diag7_b, draw_b;
    logic [17:0] err_b, rows01_b, col5_b, rnd;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        acc1   = 0;
        acc0   = 0;
        reset  = 1'b0;
        board  = '0;
        start1 = 1'b0;
        start0 = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outs_ee", outs1(), 0);
        chk("reset_outs_full", outs0(), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_ee", outs1(), 0);
        chk("post_reset_full", outs0(), 0);

        empty_b  = '0;
        row0_b   = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
        diag7_b  = mk(1, 1, 2, 2, 2, 1, 2, 1, 0);
        draw_b   = mk(1, 2, 1, 1, 2, 2, 2, 1, 1);
        err_b    = mk(0, 0, 0, 0, 3, 0, 0, 0, 0);
        rows01_b = mk(1, 1, 1, 2, 2, 2, 0, 0, 0);
        col5_b   = mk(1, 0, 2, 0, 1, 2, 0, 0, 2);

        run(empty_b, 1, 0, 0);
        run(row0_b, 1, 0, 0);
        run(diag7_b, 1, 0, 0);
        run(draw_b, 1, 0, 0);
        run(err_b, 1, 0, 0);
        run(rows01_b, 0, 0, 0);
        run(rows01_b, 1, 0, 0);
        run(row0_b, 0, 0, 0);
        run(draw_b, 0, 0, 0);
        run(err_b, 0, 0, 0);
        run(col5_b, 1, 1, 0);
        run(diag7_b, 1, 0, 1);
        run(empty_b, 0, 0, 1);

        for (int r = 0; r < 8; r++) begin
            rnd = '0;
            for (int k = 0; k < 9; k++)
                rnd[2*k +: 2] = 2'($urandom_range(0, (r == 5) ? 3 : 2));
            run(rnd, r[0], 0, 0);
        end

        q1.push_back(model(empty_b, 1));
        @(negedge clock);
        board  = empty_b;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q1.delete();
        #1;
        chk("mid_reset_outs", outs1(), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        chk("after_reset_outs", outs1(), 0);

        run(row0_b, 1, 0, 0);
        run(diag7_b, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
